// File: rtl/led_scan_ctrl.sv
// Sequencer for a registered 3-to-8 one-cold LED decoder: manual select or up/down/bounce scans with per-position dwell.
// All outputs registered; optional auto-stop after N sweeps with busy/done handshake.
module led_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [2:0] manual_sel,
  input  logic [3:0] sweeps,
  output logic [2:0] switch,
  output logic [2:0] enable,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    SCAN_UP   = 2'd1,
    SCAN_DOWN = 2'd2,
    BOUNCE    = 2'd3
  } mode_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [2:0]       EN_LIT     = 3'd4;
  localparam logic [2:0]       EN_OFF     = 3'd0;

  state_t           state, state_nxt;
  mode_t            mode_q, mode_nxt;
  logic [3:0]       sweeps_q, sweeps_nxt;
  logic [3:0]       sweep_cnt, sweep_cnt_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_cnt_nxt;
  logic             dir_up, dir_up_nxt;
  logic [2:0]       switch_nxt;
  logic [2:0]       enable_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Scan-step helpers shared by the next-state and output logic
  logic             step;
  logic             wrap;
  logic [2:0]       pos_adv;
  logic             dir_adv;
  logic [3:0]       sweep_inc;
  logic             finish;

  always_comb begin
    pos_adv = switch;
    dir_adv = dir_up;
    wrap    = 1'b0;
    case (mode_q)
      SCAN_UP: begin
        pos_adv = switch + 3'd1;
        wrap    = (switch == 3'd7);
      end
      SCAN_DOWN: begin
        pos_adv = switch - 3'd1;
        wrap    = (switch == 3'd0);
      end
      BOUNCE: begin
        if (dir_up) begin
          if (switch == 3'd7) begin
            pos_adv = 3'd6;
            dir_adv = 1'b0;
            wrap    = 1'b1;
          end else begin
            pos_adv = switch + 3'd1;
          end
        end else begin
          if (switch == 3'd0) begin
            pos_adv = 3'd1;
            dir_adv = 1'b1;
            wrap    = 1'b1;
          end else begin
            pos_adv = switch - 3'd1;
          end
        end
      end
      default: ;
    endcase
    step      = (state == RUN) && (mode_q != MANUAL) && (dwell_cnt == DWELL_LAST);
    sweep_inc = sweep_cnt + 4'd1;
    finish    = step && wrap && (sweeps_q != 4'd0) && (sweep_inc == sweeps_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; stop outranks sweep completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop || finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    mode_nxt      = mode_q;
    sweeps_nxt    = sweeps_q;
    sweep_cnt_nxt = sweep_cnt;
    dwell_cnt_nxt = dwell_cnt;
    dir_up_nxt    = dir_up;
    switch_nxt    = switch;
    enable_nxt    = enable;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        enable_nxt = EN_OFF;
        busy_nxt   = 1'b0;
        if (start) begin
          mode_nxt      = mode_t'(mode);
          sweeps_nxt    = sweeps;
          sweep_cnt_nxt = 4'd0;
          dwell_cnt_nxt = '0;
          dir_up_nxt    = 1'b1;
          enable_nxt    = EN_LIT;
          busy_nxt      = 1'b1;
          case (mode_t'(mode))
            MANUAL:    switch_nxt = manual_sel;
            SCAN_DOWN: switch_nxt = 3'd7;
            default:   switch_nxt = 3'd0;
          endcase
        end
      end
      RUN: begin
        if (stop) begin
          enable_nxt = EN_OFF;
          busy_nxt   = 1'b0;
        end else if (mode_q == MANUAL) begin
          switch_nxt = manual_sel;
        end else if (step) begin
          dwell_cnt_nxt = '0;
          if (finish) begin
            enable_nxt = EN_OFF;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
          end else begin
            switch_nxt = pos_adv;
            dir_up_nxt = dir_adv;
            // Unlimited runs keep the sweep counter parked at zero
            if (wrap && (sweeps_q != 4'd0)) sweep_cnt_nxt = sweep_inc;
          end
        end else begin
          dwell_cnt_nxt = dwell_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MANUAL;
      sweeps_q  <= 4'd0;
      sweep_cnt <= 4'd0;
      dwell_cnt <= '0;
      dir_up    <= 1'b1;
      switch    <= 3'd0;
      enable    <= EN_OFF;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mode_q    <= mode_nxt;
      sweeps_q  <= sweeps_nxt;
      sweep_cnt <= sweep_cnt_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      dir_up    <= dir_up_nxt;
      switch    <= switch_nxt;
      enable    <= enable_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: four instances with DWELL 2, 1, 4, 3 sharing all inputs except start.
module tb_led_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] manual_sel = 3'd0;
  logic [3:0] sweeps = 4'd0;
  logic       start [4];
  logic [2:0] sw    [4];
  logic [2:0] en    [4];
  logic       busy  [4];
  logic       done  [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_scan_ctrl #(.DWELL(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .start(start[0]), .stop(stop), .mode(mode),
    .manual_sel(manual_sel), .sweeps(sweeps),
    .switch(sw[0]), .enable(en[0]), .busy(busy[0]), .done(done[0]));

  led_scan_ctrl #(.DWELL(1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .start(start[1]), .stop(stop), .mode(mode),
    .manual_sel(manual_sel), .sweeps(sweeps),
    .switch(sw[1]), .enable(en[1]), .busy(busy[1]), .done(done[1]));

  led_scan_ctrl #(.DWELL(4), .CNT_W(16)) u_d4 (
    .clk(clk), .rst(rst), .start(start[2]), .stop(stop), .mode(mode),
    .manual_sel(manual_sel), .sweeps(sweeps),
    .switch(sw[2]), .enable(en[2]), .busy(busy[2]), .done(done[2]));

  led_scan_ctrl #(.DWELL(3), .CNT_W(16)) u_d3 (
    .clk(clk), .rst(rst), .start(start[3]), .stop(stop), .mode(mode),
    .manual_sel(manual_sel), .sweeps(sweeps),
    .switch(sw[3]), .enable(en[3]), .busy(busy[3]), .done(done[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int k,
                           input logic [2:0] e_sw, input logic [2:0] e_en,
                           input logic e_busy, input logic e_done);
    check({tag, ".switch"}, 32'(sw[k]), 32'(e_sw));
    check({tag, ".enable"}, 32'(en[k]), 32'(e_en));
    check({tag, ".busy"},   32'(busy[k]), 32'(e_busy));
    check({tag, ".done"},   32'(done[k]), 32'(e_done));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) start[i] = 1'b0;

    // Reset held for three cycles, then idle with no start
    repeat (3) tick();
    check_all("in_reset", 0, 3'd0, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int k = 0; k < 4; k++) check_all($sformatf("idle_c%0d_u%0d", c, k), k, 3'd0, 3'd0, 1'b0, 1'b0);
    end

    // SCAN_UP, DWELL=2, one sweep
    mode = 2'd1; sweeps = 4'd1; start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check_all($sformatf("up_c%0d", c), 0, 3'((c - 1) / 2), 3'd4, 1'b1, 1'b0);
      tick();
    end
    check_all("up_done", 0, 3'd7, 3'd0, 1'b0, 1'b1);
    tick();
    check_all("up_after", 0, 3'd7, 3'd0, 1'b0, 1'b0);

    // BOUNCE, DWELL=1, two sweeps
    mode = 2'd3; sweeps = 4'd2; start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      check_all($sformatf("bounce_c%0d", c), 1, 3'((c <= 7) ? c : 14 - c), 3'd4, 1'b1, 1'b0);
      tick();
    end
    check_all("bounce_done", 1, 3'd0, 3'd0, 1'b0, 1'b1);
    tick();
    check_all("bounce_after", 1, 3'd0, 3'd0, 1'b0, 1'b0);

    // SCAN_DOWN, DWELL=4, unlimited, stop with a simultaneous start
    mode = 2'd2; sweeps = 4'd0; start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      check_all($sformatf("down_c%0d", c), 2, 3'(7 - (c - 1) / 4), 3'd4, 1'b1, 1'b0);
      tick();
    end
    check_all("down_stopcyc", 2, 3'd2, 3'd4, 1'b1, 1'b0);
    stop = 1'b1; start[2] = 1'b1;
    tick();
    stop = 1'b0; start[2] = 1'b0;
    check_all("down_stopped", 2, 3'd2, 3'd0, 1'b0, 1'b0);
    tick();
    check_all("down_no_restart", 2, 3'd2, 3'd0, 1'b0, 1'b0);

    // MANUAL with select changes and ignored start pulses
    mode = 2'd0; manual_sel = 3'd5; start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    manual_sel = 3'd2;
    check_all("man_first", 2, 3'd5, 3'd4, 1'b1, 1'b0);
    tick();
    check_all("man_change", 2, 3'd2, 3'd4, 1'b1, 1'b0);
    mode = 2'd1; start[2] = 1'b1; manual_sel = 3'd6;
    tick();
    start[2] = 1'b0;
    check_all("man_start_ignored", 2, 3'd6, 3'd4, 1'b1, 1'b0);
    tick();
    check_all("man_still_manual", 2, 3'd6, 3'd4, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_all("man_stopped", 2, 3'd6, 3'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a SCAN_UP run, DWELL=3
    mode = 2'd1; sweeps = 4'd0; start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    repeat (12) tick();
    check_all("arst_pre", 3, 3'd4, 3'd4, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_all("arst_now", 3, 3'd0, 3'd0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    tick();
    check_all("arst_after", 3, 3'd0, 3'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Sequencer for the registered 3-to-8 one-cold LED decoder. It drives the decoder's switch and enable inputs so that a single LED is lit at a time.
- Supports a manual select mode plus automatic up, down and bounce scans. Each position is held for a programmable dwell time.
- Optionally stops after a requested number of sweeps, with a busy/done handshake to the requesting logic.

Parameters:
- DWELL, 4, clock cycles each scan position is held (legal range 1..65535)
- CNT_W, 16, dwell counter width; must satisfy 2**CNT_W >= DWELL

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a sequence; sampled only in IDLE
- stop  input  1  abort request; returns the block to IDLE
- mode  input  2  0=MANUAL, 1=SCAN_UP, 2=SCAN_DOWN, 3=BOUNCE; sampled with start
- manual_sel  input  3  LED index used in MANUAL mode; tracked every cycle
- sweeps  input  4  number of sweeps before auto-stop; 0 = run until stop; sampled with start
- switch  output  3  LED index to decoder, registered
- enable  output  3  decoder enable code, registered; 3'd4 = lit, 3'd0 = all off
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the sweep count completes

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, switch=0, enable=0, busy=0, done=0, dwell counter=0, sweep counter=0, dir=up.
- Every output is a register. No combinational path exists from any input to any output.
- States:
  - IDLE: enable=0, busy=0.
  - RUN: enable=3'd4, busy=1.
- IDLE -> RUN: start=1 at edge k. mode and sweeps are latched at edge k. From cycle k+1, busy=1, enable=4, and switch holds the initial position:
  - UP: 0
  - DOWN: 7
  - BOUNCE: 0, with dir=up
  - MANUAL: manual_sel as sampled at edge k
- start while in RUN is ignored.
- RUN -> IDLE on stop=1: at the next edge, enable=0, busy=0, done=0. The switch value is held.
- stop has priority over start and over sweep completion in the same cycle. No done pulse is produced on a stop.
- MANUAL: switch<=manual_sel every cycle, giving 1-cycle latency. No dwell counting and no sweeps; exits only on stop.
- Scan modes:
  - Dwell counter counts 0..DWELL-1. The position advances at the edge where the counter equals DWELL-1, and the counter returns to 0.
  - Each position is therefore shown for exactly DWELL cycles. With DWELL=1 the position advances every cycle.
- Position advance:
  - UP: 7 -> 0 wraps. A sweep completes when leaving 7.
  - DOWN: 0 -> 7 wraps. A sweep completes when leaving 0.
  - BOUNCE: 0,1,..,7,6,..,0,1,... Each endpoint is shown for only one dwell; direction flips when leaving an endpoint. A sweep completes when leaving 7 and when leaving 0.
- Sweep counting:
  - 4-bit counter, incremented on each sweep completion.
  - If latched sweeps != 0 and the completion makes the count equal sweeps, the same edge sets state=IDLE, enable=0, busy=0 and done=1 for one cycle. The switch value is held.
  - If latched sweeps == 0, no auto-stop occurs and the counter is frozen at 0.
- start is accepted in the cycle done is high: done is high in IDLE, so the restart is legal.
- Reset asserted mid-RUN: immediate IDLE with all reset values. No done pulse.

Test Plan:
- Reset then idle: rst low for 3 cycles, release, no start -> enable=0, switch=0, busy=0, done=0 for 10 cycles.
- SCAN_UP, DWELL=2, sweeps=1: start at cycle 0 -> switch = 0,0,1,1,...,7,7 over cycles 1..16 with enable=4. At cycle 17: enable=0, busy=0, done=1 for exactly that one cycle.
- BOUNCE, DWELL=1, sweeps=2: start -> switch sequence 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0, then IDLE with a done pulse. Total 15 RUN cycles.
- SCAN_DOWN, sweeps=0, stop after 20 cycles (DWELL=4) -> switch = 7,7,7,7,6,... then 2 at the stop cycle. Next cycle: enable=0, busy=0, done=0. A start issued in the same cycle as that stop is ignored.
- MANUAL: start with manual_sel=5, then drive manual_sel=2 -> switch=5, then 2 one cycle after the change, enable=4 throughout. start pulses during RUN have no effect.
- Async reset mid-scan: SCAN_UP, DWELL=3, drop rst between clock edges at switch=4 -> enable=0, switch=0, busy=0 immediately, without waiting for a clock edge.
